btn_conditioner: RTL

//  Upstream front end of the higher/lower game. Takes the two raw pushbutton pins
//  and drives the game's btn_higher/btn_lower inputs. Synchronises and debounces

---
 rtl/btn_pkg.sv | 16 +
 rtl/debounce_channel.sv | 55 +++++
 rtl/btn_conditioner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared arbiter state encoding and default timing for the button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD_H = 2'd1,
    HELD_L = 2'd2,
    LOCK   = 2'd3
  } arb_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int DEF_DB_W            = 18;
  localparam int DEF_REPEAT_CYCLES   = 12_500_000;
  localparam int DEF_RP_W            = 24;

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-FF synchroniser, hold counter, accepted level and
// single-cycle rise/fall strobes aligned with the cycle the level changes.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic            sync_1;
  logic            sync_2;
  logic [DB_W-1:0] cnt;
  logic            cnt_done;

  assign cnt_done = (cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Any return to the accepted level restarts the count from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt_done) begin
        stable <= sync_2;
        rise   <= sync_2;
        fall   <= !sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the higher/lower pins and arbitrates them into exclusive one-cycle
// press pulses. Define BTN_REPEAT_EN to build the auto-repeat counter.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int RP_W            = DEF_RP_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_higher_raw,
  input  logic btn_lower_raw,
  output logic btn_higher,
  output logic btn_lower,
  output logic lock
);

  logic stable_h, rise_h, fall_h;
  logic stable_l, rise_l, fall_l;
  logic unused_fall;

  arb_state_t state;
  arb_state_t state_nxt;
  logic       pulse_h_d;
  logic       pulse_l_d;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_higher (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_higher_raw),
    .stable (stable_h),
    .rise   (rise_h),
    .fall   (fall_h)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lower (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (btn_lower_raw),
    .stable (stable_l),
    .rise   (rise_l),
    .fall   (fall_l)
  );

  assign unused_fall = fall_h ^ fall_l;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise_h && rise_l)             state_nxt = LOCK;
        else if (rise_h && !stable_l)     state_nxt = HELD_H;
        else if (rise_l && !stable_h)     state_nxt = HELD_L;
        else if (rise_h || rise_l)        state_nxt = LOCK;
      end
      HELD_H: begin
        if (rise_l)                       state_nxt = LOCK;
        else if (!stable_h && !stable_l)  state_nxt = IDLE;
      end
      HELD_L: begin
        if (rise_h)                       state_nxt = LOCK;
        else if (!stable_h && !stable_l)  state_nxt = IDLE;
      end
      LOCK: begin
        if (!stable_h && !stable_l)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BTN_REPEAT_EN
  logic [RP_W-1:0] rep_cnt;
  logic            rep_hit;
  logic            held;

  assign held    = (state == HELD_H) || (state == HELD_L);
  assign rep_hit = held && (state_nxt == state) && (rep_cnt == RP_W'(REPEAT_CYCLES - 1));

  // Held in zero through every pulse cycle, so consecutive pulses are
  // REPEAT_CYCLES+1 cycles apart, matching the initial-pulse spacing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!held || (state_nxt != state) || btn_higher || btn_lower || rep_hit) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  always_comb begin
    pulse_h_d = ((state == IDLE) && (state_nxt == HELD_H)) || (rep_hit && (state == HELD_H));
    pulse_l_d = ((state == IDLE) && (state_nxt == HELD_L)) || (rep_hit && (state == HELD_L));
  end
`else
  logic [31:0] unused_rep_cfg;
  assign unused_rep_cfg = REPEAT_CYCLES ^ RP_W;

  always_comb begin
    pulse_h_d = (state == IDLE) && (state_nxt == HELD_H);
    pulse_l_d = (state == IDLE) && (state_nxt == HELD_L);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_higher <= 1'b0;
      btn_lower  <= 1'b0;
    end else begin
      btn_higher <= pulse_h_d;
      btn_lower  <= pulse_l_d;
    end
  end

  assign lock = (state == LOCK);

endmodule
